// File: rtl/pq_pkg.sv
// Shared types and defaults for the priority-queue test slice (queue, LFSR, stimulus driver).
package pq_pkg;

  localparam int PQ_KW    = 4;
  localparam int PQ_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } pq_stim_state_t;

endpackage

// File: rtl/pq_drain_checker.sv
// Drain-order monitor: flags any drained key smaller than the one drained before it.
module pq_drain_checker
  import pq_pkg::*;
#(
  parameter int KW = PQ_KW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          chk_fire,
  input  logic [KW-1:0] key,
  output logic          err
);

  logic [KW-1:0] last_key;
  logic          have_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      have_last <= 1'b0;
      err       <= 1'b0;
    end else if (clr) begin
      have_last <= 1'b0;
      err       <= 1'b0;
    end else if (chk_fire) begin
      if (have_last && (key < last_key)) err <= 1'b1;
      have_last <= 1'b1;
    end
  end

  // have_last qualifies last_key, so the key itself needs no reset
  always_ff @(posedge clk) begin
    if (chk_fire) last_key <= key;
  end

endmodule

// File: rtl/pq_stim_gen.sv
// Random enqueue/dequeue driver for the priority queue, paced by the LFSR enable.
// Define PQ_STIM_CHECK_EN to enable the drain-order checker (err); otherwise err is tied low.
module pq_stim_gen
  import pq_pkg::*;
#(
  parameter int KW    = PQ_KW,
  parameter int DEPTH = PQ_DEPTH,
  parameter int N_OPS = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] rnd,
  output logic          rnd_enb,
  output logic          enq_valid,
  output logic [KW-1:0] enq_key,
  output logic          deq_valid,
  input  logic          pq_ready,
  input  logic [KW-1:0] deq_key,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int OPS_W = $clog2(N_OPS + 1);

  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [OPS_W-1:0] OPS_LAST = OPS_W'(N_OPS - 1);

  pq_stim_state_t   state, state_nxt;
  logic [OCC_W-1:0] occ;
  logic [OPS_W-1:0] op_cnt;
  logic             start_run;
  logic             run_enq;
  logic             fire;

  assign start_run = start && ((state == IDLE) || (state == DONE));

  // Forced choices at the occupancy limits keep occ inside [0, DEPTH]
  always_comb begin
    run_enq = 1'b0;
    if (occ == '0)            run_enq = 1'b1;
    else if (occ == OCC_FULL) run_enq = 1'b0;
    else                      run_enq = rnd[0];
  end

  assign fire = (enq_valid || deq_valid) && pq_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (fire && (op_cnt == OPS_LAST)) state_nxt = DRAIN;
      DRAIN:   if ((occ == '0) || (fire && (occ == OCC_ONE))) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    enq_valid = 1'b0;
    deq_valid = 1'b0;
    enq_key   = '0;
    rnd_enb   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      RUN: begin
        busy      = 1'b1;
        enq_valid = run_enq;
        deq_valid = !run_enq;
        enq_key   = run_enq ? rnd : '0;
        // a request is always presented in RUN, so fire reduces to pq_ready
        rnd_enb   = pq_ready;
      end
      DRAIN: begin
        busy      = 1'b1;
        deq_valid = (occ != '0);
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ    <= '0;
      op_cnt <= '0;
    end else if (start_run) begin
      occ    <= '0;
      op_cnt <= '0;
    end else if (fire) begin
      if (enq_valid) occ <= occ + OCC_ONE;
      else           occ <= occ - OCC_ONE;
      if (state == RUN) op_cnt <= op_cnt + OPS_W'(1);
    end
  end

`ifdef PQ_STIM_CHECK_EN
  logic drain_fire;

  assign drain_fire = fire && (state == DRAIN);

  pq_drain_checker #(
    .KW(KW)
  ) u_drain_checker (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_run),
    .chk_fire (drain_fire),
    .key      (deq_key),
    .err      (err)
  );
`else
  logic unused_deq_key;

  assign unused_deq_key = ^deq_key;
  assign err            = 1'b0;
`endif

endmodule

// File: doc/pq_stim_gen.md
# pq_stim_gen

Stimulus driver that sits directly downstream of the 4-bit LFSR and upstream of the priority queue under test. It consumes one pseudo-random word per issued operation, turns it into either an enqueue (key = random word) or a dequeue, and paces the LFSR through its enable. After a fixed number of mixed operations it drains the queue to empty and, optionally, checks that drained keys come out in non-decreasing order (min-queue).

## Interface
Parameters:
- KW, 4, key width; equals LFSR width
- DEPTH, 8, priority-queue capacity in entries
- N_OPS, 32, handshaked operations per run before draining

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  single-cycle pulse; begins a run from IDLE or DONE
- rnd  in  KW  random word from LFSR output q
- rnd_enb  out  1  drives LFSR enb; advances LFSR one step
- enq_valid  out  1  enqueue request
- enq_key  out  KW  key to enqueue
- deq_valid  out  1  dequeue request
- pq_ready  in  1  queue accepts the presented request this cycle
- deq_key  in  KW  key returned by queue; valid when deq_valid && pq_ready
- busy  out  1  high in RUN or DRAIN
- done  out  1  high in DONE
- err  out  1  sticky drain-order error

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE. Reset -> IDLE.
- IDLE/DONE: start -> RUN; clears op_cnt, err, last-key register. start ignored in RUN/DRAIN.
- RUN: exactly one of enq_valid/deq_valid high every cycle. Op choice: occ==0 -> enqueue; occ==DEPTH -> dequeue; else rnd[0]=1 -> enqueue, rnd[0]=0 -> dequeue. enq_key = rnd.
- fire = (enq_valid||deq_valid) && pq_ready. On fire: occ +1 (enq) or -1 (deq); op_cnt +1.
- rnd_enb = fire in RUN only (combinational). rnd therefore stays constant while stalled, so request and key are stable until accepted.
- RUN -> DRAIN on the fire that makes op_cnt == N_OPS.
- DRAIN: deq_valid = (occ != 0), enq_valid = 0, rnd_enb = 0. occ==0 -> DONE (immediately if entered with occ==0).
- occ width clog2(DEPTH+1); op_cnt width clog2(N_OPS+1); never wraps (bounded by forcing rules).
- Outputs in reset: rnd_enb 0, enq_valid 0, deq_valid 0, enq_key 0, busy 0, done 0, err 0; occ 0, op_cnt 0.
- Reset asserted mid-run: immediate return to IDLE, all requests dropped same instant; no completion of pending handshake.

## Timing
- Request outputs combinational from state, occ, rnd; no added latency. Next request visible the cycle after fire (LFSR steps on the same edge).
- Throughput: one operation per cycle with pq_ready held high.
- DRAIN -> DONE one cycle after the dequeue that empties the queue; done asserts in that cycle.
- err rises the cycle after the offending deq fire; stays high until next start or rst.

## Configuration
- PQ_STIM_CHECK_EN defined: on each DRAIN fire, deq_key compared to last drained key; deq_key < last sets err. First drained key of a run only loads last.
- Undefined: err tied 0, deq_key unused, no last-key register.

## Structure
- Package pq_pkg: state enum pq_stim_state_t (IDLE, RUN, DRAIN, DONE), default KW and DEPTH constants shared with the queue and LFSR.
- Sub-module pq_drain_checker (last-key register + compare + sticky err), instantiated only under PQ_STIM_CHECK_EN.

## Test plan
- Reset (rnd=4'b0001), start, pq_ready=1 -> cycle 1: enq_valid=1, enq_key=1, rnd_enb=1, occ -> 1.
- RUN, rnd=4'b0110, occ=3, pq_ready=0 for 3 cycles -> deq_valid held 3 cycles, rnd_enb=0, occ stays 3; ready=1 -> occ 2, rnd_enb=1.
- DEPTH=8, occ=8, rnd=4'b0011 -> deq_valid=1, enq_valid=0; occ=0, rnd=4'b0100 -> enq_valid=1, enq_key=4.
- N_OPS=4, ready=1, 3 enqueues + 1 dequeue -> DRAIN with occ=2; two dequeues -> done=1, busy=0.
- With PQ_STIM_CHECK_EN, drain returns 3,5,2 -> err=1 cycle after key 2; returns 2,2,7 -> err stays 0.
- rst asserted mid-RUN with enq_valid=1 -> all outputs 0 immediately, state IDLE; start rebegins with occ=0.
